// File: rtl/dsi_pkt_sched.sv
// Purpose: shares the DSI HS link between video (req 0) and command (req 1), sequencing PREP/HDR/PAY/CRC/TRAIL.
// Latency: first HDR T_PREP+1 cycles after req is seen in IDLE; back-to-back packets have zero gap cycles.
// Backpressure: none downstream; requesters hold req until the cycle after their gnt pulse.
module dsi_pkt_sched #(
    parameter int T_PREP  = 4,
    parameter int T_TRAIL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic [1:0]  req,
    input  logic [7:0]  di0,
    input  logic [7:0]  di1,
    input  logic [15:0] wc0,
    input  logic [15:0] wc1,
    input  logic        long0,
    input  logic        long1,
    output logic [1:0]  gnt,
    output logic [23:0] hdr,
    output logic        hdr_vld,
    output logic        pay_sel,
    output logic        pay_rd,
    output logic        crc_clr,
    output logic        crc_en,
    output logic        crc_out,
    output logic        txhsen,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_HDR   = 3'd2,
        S_PAY   = 3'd3,
        S_CRC   = 3'd4,
        S_TRAIL = 3'd5
    } state_t;

    localparam logic [13:0] PREP_LD  = 14'(T_PREP - 1);
    localparam logic [13:0] TRAIL_LD = 14'(T_TRAIL - 1);

    state_t      state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic        sel_q, sel_d;

    logic        grant_any;
    logic        grant_idx;
    logic [7:0]  di_sel;
    logic [15:0] wc_sel;
    logic        long_sel;
    logic [13:0] beats;
    logic [1:0]  next_req;

    // Live arbitration: a lone requester wins; on contention vblank picks command, otherwise video.
    always_comb begin
        grant_any = |req;
        grant_idx = (req == 2'b10) || ((req == 2'b11) && vblank);
        di_sel    = grant_idx ? di1   : di0;
        wc_sel    = grant_idx ? wc1   : wc0;
        long_sel  = grant_idx ? long1 : long0;
        // ceil(wc/8) without a carry-out; 0xFFFF gives 8192, which fits the 14-bit counter.
        beats     = {1'b0, wc_sel[15:3]} + {13'd0, |wc_sel[2:0]};
    end

    // Next-state, counter and granted-index update; NEXT is folded into HDR and CRC exits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        // The just-granted requester's req is still high during HDR; it is consumed, not a new packet.
        next_req = (state_q == S_HDR) ? (req & ~gnt) : req;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_PREP;
                    cnt_d   = PREP_LD;
                end
            end
            S_PREP: begin
                if (cnt_q == 14'd0) begin
                    state_d = S_HDR;
                end else begin
                    cnt_d = cnt_q - 14'd1;
                end
            end
            S_HDR: begin
                if (!grant_any) begin
                    state_d = S_TRAIL;
                    cnt_d   = TRAIL_LD;
                end else begin
                    sel_d = grant_idx;
                    if (long_sel) begin
                        cnt_d   = beats;
                        state_d = (beats == 14'd0) ? S_CRC : S_PAY;
                    end else if (|next_req) begin
                        state_d = S_HDR;
                    end else begin
                        state_d = S_TRAIL;
                        cnt_d   = TRAIL_LD;
                    end
                end
            end
            S_PAY: begin
                if (cnt_q == 14'd1) begin
                    state_d = S_CRC;
                    cnt_d   = 14'd0;
                end else begin
                    cnt_d = cnt_q - 14'd1;
                end
            end
            S_CRC: begin
                if (|next_req) begin
                    state_d = S_HDR;
                end else begin
                    state_d = S_TRAIL;
                    cnt_d   = TRAIL_LD;
                end
            end
            S_TRAIL: begin
                if (cnt_q == 14'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 14'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 14'd0;
            end
        endcase
    end

    // State, counter and granted index; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 14'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Output decode from the state flop; header and grant use the live selection in HDR.
    always_comb begin
        hdr_vld = (state_q == S_HDR) && grant_any;
        gnt     = hdr_vld ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
        hdr     = hdr_vld ? {di_sel, wc_sel[7:0], wc_sel[15:8]} : 24'd0;
        crc_clr = hdr_vld && long_sel;
        pay_sel = 1'b0;
        if (state_q == S_HDR) begin
            pay_sel = grant_any && grant_idx;
        end else if ((state_q == S_PAY) || (state_q == S_CRC)) begin
            pay_sel = sel_q;
        end
        pay_rd  = (state_q == S_PAY);
        crc_en  = pay_rd;
        crc_out = (state_q == S_CRC);
        txhsen  = (state_q != S_IDLE);
        busy    = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_dsi_pkt_sched.sv
// Purpose: directed checks of dsi_pkt_sched timing, arbitration, word-count edges and reset.
// Latency: expected cycles are counted from the cycle k in which req is first seen in IDLE.
// Backpressure: the bench drops each req on the cycle after its gnt, as a requester would.
module tb_dsi_pkt_sched;

    logic        clk;
    logic        reset;
    logic        vblank;
    logic [1:0]  req;
    logic [7:0]  di0, di1;
    logic [15:0] wc0, wc1;
    logic        long0, long1;
    logic [1:0]  gnt;
    logic [23:0] hdr;
    logic        hdr_vld, pay_sel, pay_rd, crc_clr, crc_en, crc_out, txhsen, busy;

    dsi_pkt_sched #(.T_PREP(4), .T_TRAIL(4)) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .req(req),
        .di0(di0), .di1(di1), .wc0(wc0), .wc1(wc1), .long0(long0), .long1(long1),
        .gnt(gnt), .hdr(hdr), .hdr_vld(hdr_vld), .pay_sel(pay_sel), .pay_rd(pay_rd),
        .crc_clr(crc_clr), .crc_en(crc_en), .crc_out(crc_out), .txhsen(txhsen), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int k;

    // Monitor state, cleared per test
    int          n_hdr, n_gnt, n_pay, n_crc, n_clr, pay_first, pay_last, crc_cyc, fall_cyc;
    int          hdr_cyc [4];
    logic [23:0] hdr_val [4];
    logic [1:0]  gnt_val [4];
    logic [1:0]  gnt_prev;
    logic        prev_txh, fell, exp_sel;
    int          n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_hdr = 0; n_gnt = 0; n_pay = 0; n_crc = 0; n_clr = 0;
        pay_first = -1; pay_last = -1; crc_cyc = -1; fall_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            hdr_cyc[i] = -1; hdr_val[i] = '0; gnt_val[i] = '0;
        end
        gnt_prev = 2'b00; prev_txh = 1'b0; fell = 1'b0;
    endtask

    // Sample outputs on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        gnt_prev = gnt;
        if (hdr_vld) begin
            if (n_hdr < 4) begin
                hdr_cyc[n_hdr] = cyc; hdr_val[n_hdr] = hdr; gnt_val[n_hdr] = gnt;
            end
            n_hdr++;
        end
        if (gnt != 2'b00) n_gnt++;
        if (pay_rd) begin
            if (n_pay == 0) pay_first = cyc;
            pay_last = cyc;
            n_pay++;
            if (pay_sel != exp_sel) n_bad++;
        end
        if ((crc_en != pay_rd) || (busy != txhsen)) n_bad++;
        if (crc_out) begin crc_cyc = cyc; n_crc++; end
        if (crc_clr) n_clr++;
        if (prev_txh && !txhsen && !fell) begin fell = 1'b1; fall_cyc = cyc; end
        prev_txh = txhsen;
    end

    // Run until txhsen falls, dropping each req after its grant; optional vblank flip / req drop at k+2.
    task automatic wait_done(input logic vb2, input logic drop2, input int max);
        for (int i = 0; i < max && !fell; i++) begin
            @(posedge clk); #2;
            req = req & ~gnt_prev;
            if (cyc == k + 2) begin
                vblank = vb2;
                if (drop2) req = 2'b00;
            end
        end
        chk("burst_end", fell, 1'b1);
    endtask

    task automatic run_pkt(input logic [1:0] r, input logic vb, input logic vb2,
                           input logic drop2, input int max);
        clr_mon();
        vblank = vb;
        @(posedge clk); #2;
        req = r;
        k = cyc;
        wait_done(vb2, drop2, max);
    endtask

    logic [15:0] wc_tab    [5];
    int          beats_tab [5];

    initial begin
        reset = 1'b1; vblank = 1'b0; req = 2'b00;
        di0 = 8'h00; di1 = 8'h00; wc0 = 16'h0; wc1 = 16'h0; long0 = 1'b0; long1 = 1'b0;
        exp_sel = 1'b0;
        clr_mon();
        #3;
        chk("reset_outputs", {gnt, hdr, hdr_vld, pay_sel, pay_rd, crc_clr, crc_en, crc_out, txhsen, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("idle_no_req", busy, 1'b0);

        // Single long command packet
        di1 = 8'h37; wc1 = 16'h01F0; long1 = 1'b1; exp_sel = 1'b1;
        run_pkt(2'b10, 1'b0, 1'b0, 1'b0, 200);
        chk("long_hdr_cyc", hdr_cyc[0], k + 5);
        chk("long_hdr_val", hdr_val[0], 24'h37F001);
        chk("long_gnt",     gnt_val[0], 2'b10);
        chk("long_npay",    n_pay, 62);
        chk("long_pay_first", pay_first, k + 6);
        chk("long_pay_last",  pay_last, k + 67);
        chk("long_crc_cyc", crc_cyc, k + 68);
        chk("long_crc_clr", n_clr, 1);
        chk("long_txh_fall", fall_cyc, k + 73);

        // Contention, vblank=0: video long (1 beat) then command short, no gap
        di0 = 8'h3A; wc0 = 16'h0008; long0 = 1'b1;
        di1 = 8'h15; wc1 = 16'h0042; long1 = 1'b0; exp_sel = 1'b0;
        run_pkt(2'b11, 1'b0, 1'b0, 1'b0, 200);
        chk("arb0_hdr0_cyc", hdr_cyc[0], k + 5);
        chk("arb0_gnt0",     gnt_val[0], 2'b01);
        chk("arb0_hdr0_val", hdr_val[0], 24'h3A0800);
        chk("arb0_hdr1_cyc", hdr_cyc[1], k + 8);
        chk("arb0_gnt1",     gnt_val[1], 2'b10);
        chk("arb0_hdr1_val", hdr_val[1], 24'h154200);
        chk("arb0_txh_fall", fall_cyc, k + 13);

        // Contention, vblank rises during PREP: command first, video short next
        long0 = 1'b0;
        run_pkt(2'b11, 1'b0, 1'b1, 1'b0, 200);
        chk("arb1_gnt0",     gnt_val[0], 2'b10);
        chk("arb1_hdr1_cyc", hdr_cyc[1], k + 6);
        chk("arb1_gnt1",     gnt_val[1], 2'b01);
        chk("arb1_nhdr",     n_hdr, 2);
        chk("arb1_txh_fall", fall_cyc, k + 11);

        // Word-count edges on a long video packet
        wc_tab[0] = 16'h0000; beats_tab[0] = 0;
        wc_tab[1] = 16'h0001; beats_tab[1] = 1;
        wc_tab[2] = 16'h0008; beats_tab[2] = 1;
        wc_tab[3] = 16'h0009; beats_tab[3] = 2;
        wc_tab[4] = 16'hFFFF; beats_tab[4] = 8192;
        di0 = 8'h29; long0 = 1'b1; exp_sel = 1'b0;
        for (int t = 0; t < 5; t++) begin
            wc0 = wc_tab[t];
            run_pkt(2'b01, 1'b0, 1'b0, 1'b0, 9000);
            chk($sformatf("wc%0h_npay", wc_tab[t]), n_pay, beats_tab[t]);
            chk($sformatf("wc%0h_crc_cyc", wc_tab[t]), crc_cyc, k + 6 + beats_tab[t]);
            chk($sformatf("wc%0h_txh_fall", wc_tab[t]), fall_cyc, k + 11 + beats_tab[t]);
        end

        // Short video packet
        di0 = 8'h05; wc0 = 16'h1234; long0 = 1'b0;
        run_pkt(2'b01, 1'b0, 1'b0, 1'b0, 200);
        chk("short_nhdr",  n_hdr, 1);
        chk("short_hdr",   hdr_val[0], 24'h053412);
        chk("short_clr",   n_clr, 0);
        chk("short_crc",   n_crc, 0);
        chk("short_txh_fall", fall_cyc, k + 10);

        // Request withdrawn during PREP
        run_pkt(2'b01, 1'b0, 1'b0, 1'b1, 200);
        chk("drop_nhdr", n_hdr, 0);
        chk("drop_ngnt", n_gnt, 0);
        chk("drop_txh_fall", fall_cyc, k + 10);

        // Asynchronous reset in the middle of a 32-beat payload
        di0 = 8'h29; wc0 = 16'h0100; long0 = 1'b1;
        clr_mon();
        @(posedge clk); #2;
        req = 2'b01;
        k = cyc;
        repeat (10) begin @(posedge clk); #2; end
        chk("pre_rst_pay_rd", pay_rd, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_outputs", {gnt, hdr, hdr_vld, pay_sel, pay_rd, crc_clr, crc_en, crc_out, txhsen, busy}, 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        clr_mon();
        k = cyc;
        wait_done(1'b0, 1'b0, 200);
        chk("rst_hdr_cyc", hdr_cyc[0], k + 5);
        chk("rst_npay",    n_pay, 32);
        chk("rst_crc_cyc", crc_cyc, k + 38);

        chk("cycle_invariants", n_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dsi_pkt_sched.md
# dsi_pkt_sched

Packet scheduler for the DSI high-speed link. It shares the link between two requesters: the video line formatter (requester 0) and the DCS command engine (requester 1). It sequences each HS burst: prepare, packet header, payload beats, CRC, trail. It feeds the packet header to `dsi_ecc` and drives clear/enable for `vid_crc`. It sits between the requesters and the lane serializer control in `mipi_format_lcd`.

## Interface
Parameters:
- T_PREP, 4, cycles of HS prepare (txhsen high, no data) before the first header of a burst; 1..15.
- T_TRAIL, 4, cycles of HS trail after the last packet of a burst; 1..15.

Ports:
- clk  in  1  system clock. One clock domain only.
- reset  in  1  asynchronous, active-high reset.
- vblank  in  1  high during vertical blanking; selects the arbitration priority.
- req  in  2  per-requester packet request, level; [0]=video, [1]=command.
- di0, di1  in  8  data identifier per requester; must be stable while the matching req is high.
- wc0, wc1  in  16  word count in bytes per requester; must be stable while the matching req is high.
- long0, long1  in  1  1=long packet (payload+CRC), 0=short packet (header only).
- gnt  out  2  one-hot, one-cycle grant pulse in the HDR cycle.
- hdr  out  24  {di, wc[7:0], wc[15:8]} to `dsi_ecc`.in.
- hdr_vld  out  1  high in the HDR cycle.
- pay_sel  out  1  index of the granted requester; held from HDR through CRC.
- pay_rd  out  1  payload beat strobe, 8 bytes per beat.
- crc_clr  out  1  pulse in the HDR cycle of a long packet.
- crc_en  out  1  equals pay_rd.
- crc_out  out  1  high in the CRC cycle.
- txhsen  out  1  HS enable from PREP entry through the last TRAIL cycle.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, PREP, HDR, PAY, CRC, TRAIL.
- IDLE: if req != 0, go to PREP. Otherwise stay.
- PREP: count T_PREP cycles, then go to HDR.
- HDR (arbitration cycle): the grant is chosen combinationally from the current req and vblank.
  - Only one requester active: grant it.
  - Both active, vblank=0: grant video.
  - Both active, vblank=1: grant command.
  - The grant latches di, wc, long and the index into pay_sel. hdr and hdr_vld are driven from the live selected fields in this cycle.
  - No req active: hdr_vld=0, gnt=0, go to TRAIL.
- After HDR:
  - Short packet: go to NEXT.
  - Long packet: load beats = (wc+7)>>3. Compute it 17 bits wide; the result fits 14 bits, max 8192 for wc=0xFFFF. beats=0 goes straight to CRC. Otherwise go to PAY.
- PAY: pay_rd=1 each cycle. Decrement the counter; after the last beat go to CRC.
- CRC: crc_out=1 for one cycle, then go to NEXT.
- NEXT (a transition rule, not a state): if req != 0, go to HDR (back-to-back, no PREP, txhsen stays high). Otherwise go to TRAIL.
- TRAIL: count T_TRAIL cycles, then go to IDLE. A req rising during TRAIL is not serviced until IDLE. It then gets a full new PREP.
- Requester handshake:
  - The requester deasserts req on the cycle after it sees its gnt pulse (or later).
  - A req still high at the next arbitration point is treated as a new packet.
  - A req dropped after grant does not abort the packet.
- Reset (asynchronous, at any time, including mid-packet):
  - state=IDLE, all counters 0.
  - All outputs 0: gnt, hdr, hdr_vld, pay_sel, pay_rd, crc_clr, crc_en, crc_out, txhsen, busy.
  - No partial packet resumes after reset.
- No starvation guard. The command requester may wait for vblank indefinitely while video requests back-to-back.

## Timing
- Fresh burst: req is sampled high in IDLE at edge k.
  - PREP occupies cycles k+1..k+T_PREP.
  - HDR is at k+T_PREP+1.
- Long packet with B beats: PAY occupies B cycles after HDR, then 1 CRC cycle.
- Short packet: 1 cycle (HDR only).
- Back-to-back: the next HDR immediately follows the previous HDR (short) or CRC (long). There are zero gap cycles.
- dsi_ecc adds one cycle of latency. The formatter aligns ECC to hdr_vld delayed by 1; the scheduler does not compensate.
- txhsen falls on the cycle after the last TRAIL cycle; busy falls with it.
- Simultaneous requests: resolved only in HDR cycles using that cycle's vblank. A vblank change during PREP is honoured.

## Test plan
- Single long packet, T_PREP=4, T_TRAIL=4. req[1]=1 at edge k with di1=0x37, wc1=0x01F0, long1=1.
  - Expect PREP k+1..k+4; HDR at k+5 with hdr=0x37F001 and gnt=2'b10.
  - dsi_ecc output then ends in 0x3F.
  - 62 pay_rd cycles k+6..k+67; crc_out at k+68; TRAIL k+69..k+72; txhsen=0 at k+73.
- Arbitration, both req held:
  - vblank=0: first HDR grants video.
  - vblank=1: first HDR grants command.
  - Second packet follows with zero gap, txhsen continuously high.
- Word-count edges:
  - wc=0 long: HDR then CRC directly, no pay_rd.
  - wc=1: 1 beat. wc=8: 1 beat. wc=9: 2 beats.
  - wc=0xFFFF: 8192 beats, counter must not wrap.
- Short packet (di0=0x05, long0=0): exactly one hdr_vld, no crc_clr, no crc_out, then TRAIL.
- Requester drops req during PREP: HDR with hdr_vld=0 and gnt=0, then TRAIL, then IDLE.
- Async reset asserted mid-PAY: all outputs 0 immediately. After release with req held, a full PREP (4 cycles) precedes a new HDR.
